// File: rtl/eject_sched_pkg.sv
// Shared NoC constants for the ejection scheduler: golden-ID defaults,
// the default-sized golden-ID record and the LFSR feedback tap mask.
package eject_sched_pkg;

   localparam int NUM_NODE_DEF = 16;
   localparam int NUM_SEQ_DEF  = 8;

   // Right-shifting Fibonacci form: taps 16,14,13,11 map to state bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   typedef struct packed {
      logic [$clog2(NUM_NODE_DEF)-1:0] node;
      logic [$clog2(NUM_SEQ_DEF)-1:0]  seq;
   } gold_id_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR advancing every cycle; loads seed while reset is high.
module lfsr16
   import eject_sched_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] seed,
   output logic [15:0] state
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   always_comb begin
      state_d = {^(state_q & LFSR_TAPS), state_q[15:1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= seed;
      else       state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/eject_sched.sv
// Ejection-stage sequencer: random arbitration value, silver pick, golden-ID epochs.
// Credit gating of ejection is built only when EJECT_CREDIT_EN is defined.
module eject_sched
   import eject_sched_pkg::*;
#(
   parameter int          NUM_NODE   = NUM_NODE_DEF,
   parameter int          NUM_SEQ    = NUM_SEQ_DEF,
   parameter int          GOLD_EPOCH = 64,
   parameter int          EJ_DEPTH   = 4,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [3:0]                  vld_vec,
   input  logic [3:0]                  gold_vec,
   input  logic                        eject_fire,
   input  logic                        credit_ret,
   output logic [1:0]                  rand_num,
   output logic [3:0]                  silver_vec,
   output logic                        eject_en,
   output logic [$clog2(NUM_NODE)-1:0] golden_node,
   output logic [$clog2(NUM_SEQ)-1:0]  golden_seq,
   output logic                        epoch_start,
   output logic                        err_credit
);

   localparam int NODE_W = $clog2(NUM_NODE);
   localparam int SEQ_W  = $clog2(NUM_SEQ);
   localparam int EP_W   = $clog2(GOLD_EPOCH);

   localparam logic [NODE_W-1:0] NODE_LAST = NODE_W'(NUM_NODE - 1);
   localparam logic [SEQ_W-1:0]  SEQ_LAST  = SEQ_W'(NUM_SEQ - 1);
   localparam logic [EP_W-1:0]   EP_LAST   = EP_W'(GOLD_EPOCH - 1);

   logic [15:0] lfsr_state;

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (LFSR_SEED),
      .state (lfsr_state)
   );

   // The LFSR state is itself a flop, so its low bits are the registered value.
   assign rand_num = lfsr_state[1:0];
   logic unused_lfsr;
   assign unused_lfsr = ^lfsr_state[15:2];

   logic [3:0] qual;
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_qual
         assign qual[gi] = vld_vec[gi] & ~gold_vec[gi];
      end
   endgenerate

   logic       found;
   logic [1:0] idx;

   always_comb begin
      silver_vec = '0;
      found      = 1'b0;
      idx        = rand_num;
      for (int i = 0; i < 4; i++) begin
         idx = rand_num + 2'(i);
         if (!found && qual[idx]) begin
            silver_vec[idx] = 1'b1;
            found           = 1'b1;
         end
      end
   end

   logic [EP_W-1:0]   ep_cnt_q, ep_cnt_d;
   logic [NODE_W-1:0] node_q, node_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic              epoch_start_q, epoch_start_d;
   logic              ep_wrap;

   always_comb begin
      ep_wrap       = (ep_cnt_q == EP_LAST);
      ep_cnt_d      = ep_wrap ? '0 : ep_cnt_q + 1'b1;
      epoch_start_d = ep_wrap;
      node_d        = node_q;
      seq_d         = seq_q;
      if (ep_wrap) begin
         if (seq_q == SEQ_LAST) begin
            seq_d  = '0;
            node_d = (node_q == NODE_LAST) ? '0 : node_q + 1'b1;
         end else begin
            seq_d = seq_q + 1'b1;
         end
      end
   end

   // epoch_start resets high: the first cycle out of reset opens an epoch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ep_cnt_q      <= '0;
         node_q        <= '0;
         seq_q         <= '0;
         epoch_start_q <= 1'b1;
      end else begin
         ep_cnt_q      <= ep_cnt_d;
         node_q        <= node_d;
         seq_q         <= seq_d;
         epoch_start_q <= epoch_start_d;
      end
   end

   assign golden_node = node_q;
   assign golden_seq  = seq_q;
   assign epoch_start = epoch_start_q;

`ifdef EJECT_CREDIT_EN
   localparam int              CR_W   = $clog2(EJ_DEPTH + 1);
   localparam logic [CR_W-1:0] CR_MAX = CR_W'(EJ_DEPTH);

   logic [CR_W-1:0] cr_q, cr_d;
   logic            err_q, err_d;

   always_comb begin
      cr_d  = cr_q;
      err_d = err_q;
      case ({eject_fire, credit_ret})
         2'b10: begin
            if (cr_q == '0) err_d = 1'b1;
            else            cr_d  = cr_q - 1'b1;
         end
         2'b01: begin
            if (cr_q == CR_MAX) err_d = 1'b1;
            else                cr_d  = cr_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cr_q  <= CR_MAX;
         err_q <= 1'b0;
      end else begin
         cr_q  <= cr_d;
         err_q <= err_d;
      end
   end

   assign eject_en   = (cr_q != '0);
   assign err_credit = err_q;
`else
   logic unused_credit;
   assign unused_credit = eject_fire ^ credit_ret;
   assign eject_en      = 1'b1;
   assign err_credit    = 1'b0;
`endif

endmodule

// File: tb/tb_eject_sched.sv
// Directed bench for eject_sched: LFSR sequence, silver pick, golden epochs,
// credit gating (EJECT_CREDIT_EN builds) and asynchronous mid-epoch reset.
module tb_eject_sched;
   import eject_sched_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] vld_vec, gold_vec;
   logic       eject_fire, credit_ret;
   logic [1:0] rand_num;
   logic [3:0] silver_vec;
   logic       eject_en;
   logic [3:0] golden_node;
   logic [2:0] golden_seq;
   logic       epoch_start;
   logic       err_credit;

   eject_sched dut (
      .clk         (clk),
      .reset       (reset),
      .vld_vec     (vld_vec),
      .gold_vec    (gold_vec),
      .eject_fire  (eject_fire),
      .credit_ret  (credit_ret),
      .rand_num    (rand_num),
      .silver_vec  (silver_vec),
      .eject_en    (eject_en),
      .golden_node (golden_node),
      .golden_seq  (golden_seq),
      .epoch_start (epoch_start),
      .err_credit  (err_credit)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic [15:0] m;
   logic [3:0]  silver_done = 4'h0;
   gold_id_t    exp_id;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
   endtask

   task automatic apply_silver(input logic [3:0] v, input logic [3:0] g, input logic [3:0] exp,
                               input string tag);
      vld_vec  = v;
      gold_vec = g;
      #1;
      chk(tag, 32'(silver_vec), 32'(exp));
      $display("silver rand=%0d vld=%b gold=%b silver=%b", rand_num, v, g, silver_vec);
   endtask

   // One directed silver case per rand_num value, run at its first occurrence.
   task automatic silver_try();
      if (!silver_done[m[1:0]]) begin
         silver_done[m[1:0]] = 1'b1;
         case (m[1:0])
            2'd0: apply_silver(4'b1111 & 4'b1010, 4'b0000, 4'b0010, "silver_r0");
            2'd1: apply_silver(4'b0001, 4'b0000, 4'b0001, "silver_r1_wrap");
            2'd2: begin
               apply_silver(4'b1111, 4'b0100, 4'b1000, "silver_r2_skip_gold");
               apply_silver(4'b0100, 4'b0100, 4'b0000, "silver_r2_none");
            end
            default: apply_silver(4'b1111, 4'b1001, 4'b0010, "silver_r3_wrap_gold");
         endcase
         vld_vec  = 4'h0;
         gold_vec = 4'h0;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rand"},  32'(rand_num),    32'h1);
      chk({tag, "_node"},  32'(golden_node), 32'h0);
      chk({tag, "_seq"},   32'(golden_seq),  32'h0);
      chk({tag, "_epst"},  32'(epoch_start), 32'h1);
      chk({tag, "_ejen"},  32'(eject_en),    32'h1);
      chk({tag, "_err"},   32'(err_credit),  32'h0);
   endtask

   initial begin
      reset      = 1'b1;
      vld_vec    = 4'h0;
      gold_vec   = 4'h0;
      eject_fire = 1'b0;
      credit_ret = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc   = 0;
      m     = 16'hACE1;
      chk_reset_vals("rst0");
      silver_try();

      // 8 epochs of 64 cycles: golden_seq walks 0..7, then node steps to 1.
      for (int i = 1; i <= 512; i++) begin
         tick();
         chk("rand_num", 32'(rand_num), 32'(m[1:0]));
         chk("epoch_start", 32'(epoch_start), 32'((cyc % 64) == 0));
         if ((cyc % 64) == 0) begin
            exp_id.node = 4'(cyc / 512);
            exp_id.seq  = 3'((cyc / 64) % 8);
            chk("golden_seq", 32'(golden_seq), 32'(exp_id.seq));
            chk("golden_node", 32'(golden_node), 32'(exp_id.node));
            $display("epoch cyc=%0d node=%0d seq=%0d", cyc, golden_node, golden_seq);
         end
         silver_try();
      end
      chk("silver_all_seen", 32'(silver_done), 32'hF);

`ifdef EJECT_CREDIT_EN
      eject_fire = 1'b1;
      repeat (3) tick();
      chk("cr_after3_fire", 32'(eject_en), 32'h1);
      tick();
      chk("cr_empty_after4", 32'(eject_en), 32'h0);
      eject_fire = 1'b0;
      credit_ret = 1'b1;
      tick();
      chk("cr_ret_reenable", 32'(eject_en), 32'h1);
      tick();
      eject_fire = 1'b1;
      tick();
      chk("cr_both_no_err", 32'(err_credit), 32'h0);
      credit_ret = 1'b0;
      tick();
      chk("cr_both_kept2_a", 32'(eject_en), 32'h1);
      tick();
      chk("cr_both_kept2_b", 32'(eject_en), 32'h0);
      eject_fire = 1'b0;
      credit_ret = 1'b1;
      repeat (4) tick();
      chk("cr_full_no_err", 32'(err_credit), 32'h0);
      tick();
      chk("cr_overflow_err", 32'(err_credit), 32'h1);
      chk("cr_overflow_en", 32'(eject_en), 32'h1);
      credit_ret = 1'b0;
      $display("credit sequence done err=%0d", err_credit);
`else
      eject_fire = 1'b1;
      repeat (4) tick();
      chk("nocr_en", 32'(eject_en), 32'h1);
      chk("nocr_err", 32'(err_credit), 32'h0);
      eject_fire = 1'b0;
      credit_ret = 1'b1;
      repeat (2) tick();
      chk("nocr_err_ret", 32'(err_credit), 32'h0);
      credit_ret = 1'b0;
      $display("credit disabled: eject_en=%0d err=%0d", eject_en, err_credit);
`endif

      // Advance to ep_cnt = 30 of the epoch that began at cycle 512.
      while (cyc < 542) tick();
      chk("pre_rst_node", 32'(golden_node), 32'h1);
      chk("pre_rst_seq", 32'(golden_seq), 32'h0);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("midrst");
      $display("mid-epoch reset applied at cyc=%0d", cyc);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc   = 0;
      m     = 16'hACE1;
      chk("post_rst_epst", 32'(epoch_start), 32'h1);
      for (int i = 1; i <= 64; i++) begin
         tick();
         chk("post_rst_epoch", 32'(epoch_start), 32'(cyc == 64));
      end
      chk("post_rst_seq", 32'(golden_seq), 32'h1);
      chk("post_rst_rand", 32'(rand_num), 32'(m[1:0]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eject_sched.md
# eject_sched

Sequencing controller for the router ejection stage. It supplies the per-cycle 2-bit random arbitration value and the one-hot silver-flit selection consumed by the 4-to-1 local ejection arbiter. It rotates the network-wide golden packet identity at fixed epoch boundaries, and gates ejection with a credit counter tracking free slots in the local NI ejection buffer. One instance per router, beside the ejector.

## Interface
Parameters:
- NUM_NODE, 16: number of routers; golden_node range is 0..NUM_NODE-1.
- NUM_SEQ, 8: packet sequence IDs per node; golden_seq range is 0..NUM_SEQ-1.
- GOLD_EPOCH, 64: cycles per golden epoch; must be ≥2.
- EJ_DEPTH, 4: NI ejection buffer depth in flits; must be ≥1.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk, input, 1: the block's single clock.
- reset, input, 1: asynchronous, active-high reset.
- vld_vec, input, 4: per-channel valid bits of the flits entering the ejector.
- gold_vec, input, 4: per-channel golden bits.
- eject_fire, input, 1: a flit was delivered on dout_local this cycle.
- credit_ret, input, 1: the NI freed one ejection slot this cycle.
- rand_num, output, 2: arbitration random value.
- silver_vec, output, 4: one-hot or zero silver selection.
- eject_en, output, 1: ejection permitted this cycle.
- golden_node, output, $clog2(NUM_NODE): current golden node.
- golden_seq, output, $clog2(NUM_SEQ): current golden sequence ID.
- epoch_start, output, 1: one-cycle pulse in the first cycle of each new epoch.
- err_credit, output, 1: sticky credit-protocol error flag.

## Operation
- LFSR: 16-bit Fibonacci register, taps 16,14,13,11, advances every cycle. rand_num = lfsr[1:0], registered.
- Silver selection is combinational from the registered rand_num:
  - Scan channels starting at index rand_num, increasing mod 4.
  - The first channel with vld_vec=1 and gold_vec=0 gets the one-hot bit.
  - If no channel qualifies, silver_vec = 0.
- Epoch counter ep_cnt counts 0..GOLD_EPOCH-1. When ep_cnt = GOLD_EPOCH-1:
  - ep_cnt returns to 0.
  - golden_seq increments.
  - If golden_seq was NUM_SEQ-1, golden_seq becomes 0 and golden_node increments mod NUM_NODE.
  - epoch_start = 1 in the following cycle only.
- Credit counter cr counts 0..EJ_DEPTH, width $clog2(EJ_DEPTH+1). eject_en = (cr != 0), decoded from the register.
  - eject_fire only: cr decrements.
  - credit_ret only: cr increments.
  - Both in the same cycle: cr is unchanged.
  - eject_fire while cr = 0: cr stays 0 and err_credit is set.
  - credit_ret while cr = EJ_DEPTH (without eject_fire): cr stays at EJ_DEPTH and err_credit is set.
- err_credit clears only on reset.

## Timing
- Reset values:
  - lfsr = LFSR_SEED, so rand_num = 2'b01.
  - ep_cnt = 0, golden_node = 0, golden_seq = 0.
  - epoch_start = 1 (the first cycle after reset counts as an epoch start).
  - cr = EJ_DEPTH, eject_en = 1, err_credit = 0.
  - silver_vec follows its combinational inputs.
- rand_num, golden_node, golden_seq and eject_en are registered. Each changes only on a clk edge, one cycle after the event that causes it.
- silver_vec has zero-cycle latency from vld_vec and gold_vec.
- When reset asserts mid-operation, every register returns to its reset value immediately. The first epoch after reset deassertion lasts exactly GOLD_EPOCH cycles.
- Golden ID wraps from (NUM_NODE-1, NUM_SEQ-1) to (0, 0).

## Configuration
- EJECT_CREDIT_EN defined: credit counter, eject_en gating and err_credit are implemented as described above.
- EJECT_CREDIT_EN undefined: no credit counter is built. eject_en = 1 and err_credit = 0 at all times, and eject_fire and credit_ret are ignored.

## Structure
- The shared NoC package holds:
  - the NUM_NODE and NUM_SEQ defaults;
  - the golden-ID typedef (node and seq fields);
  - the LFSR tap constant.
- The LFSR is a sub-module named lfsr16, with ports clk, reset and seed, and a 16-bit state output.
- Everything else (epoch counter, golden ID, credit counter, silver selection) is in eject_sched.

## Test plan
- Reset, then run 4 cycles. Required: rand_num = 01 in cycle 0, then follows the LFSR sequence computed from seed ACE1 with taps 16,14,13,11. golden_node and golden_seq = 0. eject_en = 1.
- Default parameters, run 64×8 cycles. Required:
  - epoch_start pulses every 64 cycles.
  - golden_seq steps 0..7.
  - After 512 cycles, golden_node = 1 and golden_seq = 0.
- Force rand_num = 2, vld_vec = 1111, gold_vec = 0100. Required: silver_vec = 1000. With vld_vec = 0100, required: silver_vec = 0000.
- EJ_DEPTH = 4, 4 consecutive eject_fire pulses. Required: eject_en = 0 after the 4th. One credit_ret brings eject_en back to 1 on the next cycle.
- Assert eject_fire and credit_ret together while cr = 2. Required: cr stays 2 and err_credit stays 0. Then credit_ret while cr = 4. Required: err_credit = 1.
- Assert reset in mid-epoch with ep_cnt = 30. Required: all registers return to their reset values asynchronously. The next epoch_start after the reset-cycle pulse occurs exactly 64 cycles after reset deassertion.
